// File: rtl/chess_clock_timer.sv
// Per-player chess countdown clock. The time is held as M:SS in BCD.
// It counts down while flag is high, adds INC_SECS when the turn ends
// (capped at 9:59), and drives three active-low seven-segment digits.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high; reloads START_MINS:00
//   flag         run enable (this player's turn, game live)
//   SegMins      minutes digit, active-low {g,f,e,d,c,b,a}
//   SegSecTens   tens-of-seconds digit, same encoding
//   SegSecUnits  units-of-seconds digit, same encoding
//   Timeout      registered, sticky flag set when the time reaches 0:00
//   LowTime      remaining time <= LOW_TIME_SECS while not timed out
module chess_clock_timer #(
  parameter int unsigned CLOCK_FREQ    = 50_000_000,
  parameter int unsigned START_MINS    = 5,
  parameter int unsigned INC_SECS      = 0,
  parameter int unsigned LOW_TIME_SECS = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flag,
  output logic [6:0] SegMins,
  output logic [6:0] SegSecTens,
  output logic [6:0] SegSecUnits,
  output logic       Timeout,
  output logic       LowTime
);

  localparam int unsigned PRESCALE_W = (CLOCK_FREQ > 2) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(CLOCK_FREQ - 1);
  localparam logic [10:0] MAX_SECS  = 11'd599;
  localparam logic [10:0] INC       = 11'(INC_SECS);
  localparam logic [6:0]  LOW_LIMIT = 7'(LOW_TIME_SECS);
  localparam logic [3:0]  START_M   = 4'(START_MINS);

  logic [3:0]            mins;
  logic [3:0]            tens;
  logic [3:0]            units;
  logic [PRESCALE_W-1:0] prescaler;
  logic                  flagD;

  logic       running;
  logic       tick;
  logic       turnEnd;
  logic       decZero;
  logic [3:0] decMins, decTens, decUnits;
  logic [3:0] incMins, incTens, incUnits;
  logic [10:0] totalSecs, sumSecs, capSecs, remSecs;
  logic [6:0] lowSecs;

  // Prescaler only advances (and therefore holds a partial second) while running.
  assign running = flag & ~Timeout;
  assign tick    = running && (prescaler == PRESCALE_MAX);
  assign turnEnd = flagD & ~flag & ~Timeout & (INC != '0);

  // One-second BCD decrement with borrow into tens and minutes.
  always_comb begin
    decMins  = mins;
    decTens  = tens;
    decUnits = units;
    if (units != 4'd0) begin
      decUnits = units - 4'd1;
    end else if (tens != 4'd0) begin
      decUnits = 4'd9;
      decTens  = tens - 4'd1;
    end else begin
      decUnits = 4'd9;
      decTens  = 4'd5;
      decMins  = mins - 4'd1;
    end
  end

  // The decrement that lands on 0:00 is the one that must raise Timeout.
  assign decZero = (mins == 4'd0) && (tens == 4'd0) && (units == 4'd1);

  // Increment goes through binary seconds so carries and the 9:59 cap are simple.
  always_comb begin
    totalSecs = 11'(mins) * 11'd60 + 11'(tens) * 11'd10 + 11'(units);
    sumSecs   = totalSecs + INC;
    capSecs   = (sumSecs > MAX_SECS) ? MAX_SECS : sumSecs;
    incMins   = 4'(capSecs / 11'd60);
    remSecs   = capSecs - 11'(incMins) * 11'd60;
    incTens   = 4'(remSecs / 11'd10);
    incUnits  = 4'(remSecs - 11'(incTens) * 11'd10);
  end

  // Time state; tick (flag high) and turnEnd (flag low) are mutually exclusive.
  always_ff @(posedge clock) begin
    if (reset) begin
      mins      <= START_M;
      tens      <= 4'd0;
      units     <= 4'd0;
      prescaler <= '0;
      flagD     <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      flagD <= flag;
      if (running) begin
        prescaler <= tick ? '0 : prescaler + PRESCALE_W'(1);
      end
      if (tick) begin
        mins  <= decMins;
        tens  <= decTens;
        units <= decUnits;
        if (decZero) begin
          Timeout <= 1'b1;
        end
      end else if (turnEnd) begin
        mins  <= incMins;
        tens  <= incTens;
        units <= incUnits;
      end
    end
  end

  assign lowSecs = 7'(tens) * 7'd10 + 7'(units);
  assign LowTime = (mins == 4'd0) && (lowSecs <= LOW_LIMIT) && !Timeout;

  function automatic logic [6:0] segCode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  assign SegMins     = segCode(mins);
  assign SegSecTens  = segCode(tens);
  assign SegSecUnits = segCode(units);

endmodule

// File: tb/tb_chess_clock_timer.sv
// Bench for chess_clock_timer: two instances (A: 1 min, no increment;
// B: 9 min, 15 s increment) with a seconds-based reference model feeding
// an expected-value queue, plus directed display checks.
module tb_chess_clock_timer;

  localparam int FREQ = 10;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic clock = 1'b0;
  logic resetA = 1'b1, flagA = 1'b0, resetB = 1'b1, flagB = 1'b0;
  logic [6:0] segMinsA, segTensA, segUnitsA, segMinsB, segTensB, segUnitsB;
  logic timeoutA, lowTimeA, timeoutB, lowTimeB;
  logic [22:0] obsA, obsB;

  chess_clock_timer #(.CLOCK_FREQ(FREQ), .START_MINS(1), .INC_SECS(0), .LOW_TIME_SECS(30)) dutA (
    .clock(clock), .reset(resetA), .flag(flagA),
    .SegMins(segMinsA), .SegSecTens(segTensA), .SegSecUnits(segUnitsA),
    .Timeout(timeoutA), .LowTime(lowTimeA));

  chess_clock_timer #(.CLOCK_FREQ(FREQ), .START_MINS(9), .INC_SECS(15), .LOW_TIME_SECS(30)) dutB (
    .clock(clock), .reset(resetB), .flag(flagB),
    .SegMins(segMinsB), .SegSecTens(segTensB), .SegSecUnits(segUnitsB),
    .Timeout(timeoutB), .LowTime(lowTimeB));

  assign obsA = {segMinsA, segTensA, segUnitsA, timeoutA, lowTimeA};
  assign obsB = {segMinsB, segTensB, segUnitsB, timeoutB, lowTimeB};

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [22:0] expA;
    logic [22:0] expB;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model state, in plain seconds.
  int secsM[2];
  int preM[2];
  bit fprevM[2];
  bit toM[2];
  int startM[2] = '{1, 9};
  int incM[2]   = '{0, 15};

  task automatic checkEq(input string tag, input logic [22:0] got, input logic [22:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return S0;
      1: return S1;
      2: return S2;
      3: return S3;
      4: return S4;
      5: return S5;
      6: return 7'b0000010;
      7: return S7;
      8: return S8;
      9: return S9;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [22:0] expOf(input int i);
    int s;
    bit low;
    s   = secsM[i];
    low = !toM[i] && (s <= 30);
    return {segOf(s / 60), segOf((s % 60) / 10), segOf(s % 10), toM[i], low};
  endfunction

  task automatic modelStep(input int i, input bit r, input bit f);
    bit oldTo;
    bit tick;
    int sum;
    oldTo = toM[i];
    if (r) begin
      secsM[i]  = startM[i] * 60;
      preM[i]   = 0;
      fprevM[i] = 1'b0;
      toM[i]    = 1'b0;
    end else begin
      tick = f && !oldTo && (preM[i] == FREQ - 1);
      if (f && !oldTo) preM[i] = tick ? 0 : preM[i] + 1;
      if (tick) begin
        secsM[i] = secsM[i] - 1;
        if (secsM[i] == 0) toM[i] = 1'b1;
      end
      if (fprevM[i] && !f && !oldTo && incM[i] > 0) begin
        sum      = secsM[i] + incM[i];
        secsM[i] = (sum > 599) ? 599 : sum;
      end
      fprevM[i] = f;
    end
  endtask

  // Drive one cycle of inputs and queue what both DUTs must show after the edge.
  task automatic step(input bit rA, input bit fA, input bit rB, input bit fB, input string tag);
    expT e;
    @(negedge clock);
    resetA = rA;
    flagA  = fA;
    resetB = rB;
    flagB  = fB;
    modelStep(0, rA, fA);
    modelStep(1, rB, fB);
    e.tag  = tag;
    e.expA = expOf(0);
    e.expB = expOf(1);
    sbQ.push_back(e);
  endtask

  // Directed check of the display right after the edge for the last step.
  task automatic expectNow(input string tag, input int i, input logic [22:0] want);
    @(posedge clock);
    #2;
    checkEq(tag, (i == 0) ? obsA : obsB, want);
  endtask

  always @(posedge clock) begin : monitor
    expT e;
    #1;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkEq({e.tag, "A"}, obsA, e.expA);
      checkEq({e.tag, "B"}, obsB, e.expB);
    end
  end

  initial begin
    int n;
    step(1, 0, 1, 0, "rst");
    expectNow("rstA", 0, {S1, S0, S0, 1'b0, 1'b0});
    step(1, 0, 1, 0, "rst");
    expectNow("rstB", 1, {S9, S0, S0, 1'b0, 1'b0});

    // First second on A.
    for (int k = 0; k < 9; k++) step(0, 1, 0, 0, "run");
    expectNow("preSecA", 0, {S1, S0, S0, 1'b0, 1'b0});
    step(0, 1, 0, 0, "run");
    expectNow("sec059A", 0, {S0, S5, S9, 1'b0, 1'b0});

    // Run down through LowTime to Timeout.
    for (int k = 0; k < 289; k++) step(0, 1, 0, 0, "run");
    expectNow("at031A", 0, {S0, S3, S1, 1'b0, 1'b0});
    step(0, 1, 0, 0, "run");
    expectNow("low030A", 0, {S0, S3, S0, 1'b0, 1'b1});
    for (int k = 0; k < 299; k++) step(0, 1, 0, 0, "run");
    expectNow("at001A", 0, {S0, S0, S1, 1'b0, 1'b1});
    step(0, 1, 0, 0, "run");
    expectNow("timeoutA", 0, {S0, S0, S0, 1'b1, 1'b0});
    for (int k = 0; k < 20; k++) step(0, 1, 0, 0, "frozen");
    expectNow("frozenA", 0, {S0, S0, S0, 1'b1, 1'b0});

    // Reset after timeout, then partial seconds held across turns.
    step(1, 1, 0, 0, "rst2");
    expectNow("rst2A", 0, {S1, S0, S0, 1'b0, 1'b0});
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, "pulse");
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, "pause");
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, "pulse");
    expectNow("pulsePreA", 0, {S1, S0, S0, 1'b0, 1'b0});
    step(0, 1, 0, 0, "pulse");
    expectNow("pulseA", 0, {S0, S5, S9, 1'b0, 1'b0});

    // Reset mid-second: a full second is needed afterwards.
    step(1, 0, 0, 0, "rst3");
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, "part");
    step(1, 1, 0, 0, "midRst");
    for (int k = 0; k < 9; k++) step(0, 1, 0, 0, "mid");
    expectNow("midPreA", 0, {S1, S0, S0, 1'b0, 1'b0});
    step(0, 1, 0, 0, "mid");
    expectNow("midA", 0, {S0, S5, S9, 1'b0, 1'b0});

    // Increment and saturation on B.
    for (int k = 0; k < 30; k++) step(0, 0, 0, 1, "bRun");
    expectNow("b857", 1, {S8, S5, S7, 1'b0, 1'b0});
    step(0, 0, 0, 0, "bEnd");
    expectNow("b912", 1, {S9, S1, S2, 1'b0, 1'b0});
    step(0, 0, 0, 1, "bTog");
    step(0, 0, 0, 0, "bEnd");
    expectNow("b927", 1, {S9, S2, S7, 1'b0, 1'b0});
    step(0, 0, 0, 1, "bTog");
    step(0, 0, 0, 0, "bEnd");
    expectNow("b942", 1, {S9, S4, S2, 1'b0, 1'b0});
    step(0, 0, 0, 1, "bTog");
    step(0, 0, 0, 0, "bEnd");
    expectNow("b957", 1, {S9, S5, S7, 1'b0, 1'b0});
    step(0, 0, 0, 1, "bTog");
    step(0, 0, 0, 0, "bEnd");
    expectNow("b959sat", 1, {S9, S5, S9, 1'b0, 1'b0});

    // Run B out, then confirm increments are frozen after Timeout.
    n = 0;
    while (!toM[1] && n < 6100) begin
      step(0, 0, 0, 1, "bLong");
      n++;
    end
    expectNow("bTimeout", 1, {S0, S0, S0, 1'b1, 1'b0});
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, "bTog2");
      step(0, 0, 0, 0, "bEnd2");
    end
    expectNow("bFrozen", 1, {S0, S0, S0, 1'b1, 1'b0});
    step(0, 0, 1, 0, "bRst");
    expectNow("bRst", 1, {S9, S0, S0, 1'b0, 1'b0});
    for (int k = 0; k < 9; k++) step(0, 0, 0, 1, "bRun2");
    step(0, 0, 0, 1, "bRun2");
    expectNow("b859", 1, {S8, S5, S9, 1'b0, 1'b0});

    step(0, 0, 0, 0, "idle");
    @(posedge clock);
    #3;
    checkEq("sbDrain", 23'(sbQ.size()), 23'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
